// File: rtl/data_sync_pkg.sv
// +----------------------------------------------------------------------------+
// | data_sync_pkg : shared state encoding and default timing for data_sync_tx   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package data_sync_pkg;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SETUP = 2'd1;
  localparam logic [1:0] c_HOLD  = 2'd2;
  localparam logic [1:0] c_GAP   = 2'd3;

  localparam int c_BUS_WIDTH    = 8;
  localparam int c_FIFO_DEPTH   = 4;
  localparam int c_SETUP_CYCLES = 1;
  localparam int c_HOLD_CYCLES  = 4;
  localparam int c_GAP_CYCLES   = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_sync_tx_fifo.sv
// +----------------------------------------------------------------------------+
// | sync_fifo_sc : single-clock FIFO with occupancy count, head-of-queue dout   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_fifo_sc #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Full refuses a push even when a pop lands in the same cycle.
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_dout    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_sync_tx.sv
// +----------------------------------------------------------------------------+
// | data_sync_tx : buffered launcher driving a held bus plus timed level enable |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module data_sync_tx
  import data_sync_pkg::*;
#(
  parameter int BUS_WIDTH    = c_BUS_WIDTH,
  parameter int FIFO_DEPTH   = c_FIFO_DEPTH,
  parameter int SETUP_CYCLES = c_SETUP_CYCLES,
  parameter int HOLD_CYCLES  = c_HOLD_CYCLES,
  parameter int GAP_CYCLES   = c_GAP_CYCLES
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [BUS_WIDTH-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [BUS_WIDTH-1:0]          Unsync_bus,
  output logic                          bus_enable,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(max3(SETUP_CYCLES, HOLD_CYCLES, GAP_CYCLES)) + 1;

  generate
    if (SETUP_CYCLES < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_timing
      $error("data_sync_tx: SETUP/HOLD/GAP cycles must all be >= 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("data_sync_tx: FIFO_DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [BUS_WIDTH-1:0] r_bus;
  logic [BUS_WIDTH-1:0] w_bus_nxt;
  logic                 r_en;
  logic                 w_en_nxt;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [BUS_WIDTH-1:0] w_fifo_dout;

  assign in_ready = ~w_fifo_full;
  assign w_push   = in_valid & in_ready;

  sync_fifo_sc #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .i_push  (w_push),
    .i_din   (in_data),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (fifo_count)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (!w_fifo_empty) w_state_nxt = c_SETUP;
      c_SETUP: if (r_cnt == '0)   w_state_nxt = c_HOLD;
      c_HOLD:  if (r_cnt == '0)   w_state_nxt = c_GAP;
      c_GAP:   if (r_cnt == '0)   w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // The bus only loads on leaving IDLE, so it stays frozen through SETUP, HOLD and GAP.
  always_comb begin
    w_pop     = 1'b0;
    w_cnt_nxt = r_cnt;
    w_bus_nxt = r_bus;
    w_en_nxt  = r_en;
    case (r_state)
      c_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop     = 1'b1;
          w_bus_nxt = w_fifo_dout;
          w_cnt_nxt = CW'(SETUP_CYCLES - 1);
        end
      end
      c_SETUP: begin
        if (r_cnt == '0) begin
          w_en_nxt  = 1'b1;
          w_cnt_nxt = CW'(HOLD_CYCLES - 1);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      c_HOLD: begin
        if (r_cnt == '0) begin
          w_en_nxt  = 1'b0;
          w_cnt_nxt = CW'(GAP_CYCLES - 1);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      c_GAP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
      r_bus <= '0;
      r_en  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_bus <= w_bus_nxt;
      r_en  <= w_en_nxt;
    end
  end

  assign Unsync_bus = r_bus;
  assign bus_enable = r_en;
  assign busy       = (r_state != c_IDLE) | ~w_fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_data_sync_tx.sv
// +----------------------------------------------------------------------------+
// | tb_data_sync_tx : directed bench with a transfer-timeline reference model   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_data_sync_tx;

  localparam int S     = 1;
  localparam int H     = 4;
  localparam int G     = 4;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] Unsync_bus;
  logic       bus_enable;
  logic       busy;
  logic [2:0] fifo_count;

  int n_cmp  = 0;
  int n_fail = 0;

  data_sync_tx dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Unsync_bus (Unsync_bus),
    .bus_enable (bus_enable),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of waiting words and the position inside the current
  // transfer window (-1 = no transfer); enable is high for positions [S, S+H).
  int         m_pos = -1;
  logic [7:0] m_cur = 8'h00;
  logic [7:0] m_q[$];
  logic [7:0] m_capq[$];
  bit         m_acc;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_pos = -1;
      m_cur = 8'h00;
      m_q.delete();
      m_capq.delete();
    end else begin
      m_acc = in_valid && (m_q.size() != DEPTH);
      if (m_pos < 0) begin
        if (m_q.size() > 0) begin
          m_cur = m_q.pop_front();
          m_capq.push_back(m_cur);
          m_pos = 0;
        end
      end else begin
        m_pos++;
        if (m_pos == S + H + G) m_pos = -1;
      end
      if (m_acc) m_q.push_back(in_data);
    end
  end

  int         cyc = 0;
  int         hi_run = 0;
  int         low_run = 100;
  bit         seen_fall = 0;
  logic       prev_en = 1'b0;
  logic [7:0] prev_bus = 8'h00;
  logic [7:0] cap_log[$];
  int         rise_log[$];

  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      hi_run = 0;
      low_run = 100;
      seen_fall = 0;
      prev_en = 1'b0;
      prev_bus = 8'h00;
    end else begin
      chk("model_bus",    Unsync_bus, m_cur);
      chk("model_enable", bus_enable, (m_pos >= S && m_pos < S + H));
      chk("model_count",  fifo_count, m_q.size());
      chk("model_ready",  in_ready,   m_q.size() != DEPTH);
      chk("model_busy",   busy,       (m_pos >= 0) || (m_q.size() != 0));
      if (Unsync_bus != prev_bus)
        chk("bus_change_window", (!bus_enable && !prev_en && low_run >= G), 1);
      if (bus_enable && !prev_en) begin
        if (seen_fall) chk("enable_low_gap", low_run >= G + 1 + S, 1);
        if (m_capq.size() > 0) chk("capture_order", Unsync_bus, m_capq.pop_front());
        else chk("capture_unexpected", 1, 0);
        cap_log.push_back(Unsync_bus);
        rise_log.push_back(cyc);
        hi_run = 0;
      end
      if (!bus_enable && prev_en) begin
        chk("pulse_len", hi_run, H);
        low_run = 0;
        seen_fall = 1;
      end
      if (bus_enable) hi_run++;
      else low_run++;
      prev_en = bus_enable;
      prev_bus = Unsync_bus;
    end
  end

  int last_wait;
  int last_cnt;

  // Caller sits 2 time units after a rising edge; returns at the same phase.
  task automatic push_word(input logic [7:0] d);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && w < 200) begin
      @(posedge CLK); #2;
      w++;
    end
    if (w >= 200) chk("push_timeout", 0, 1);
    last_wait = w;
    last_cnt  = fifo_count;
    @(posedge CLK); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(posedge CLK); #2;
      n++;
    end
    chk("drain_timeout", busy, 0);
  endtask

  logic [7:0] t2_exp [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  initial begin
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_bus",   Unsync_bus, 8'h00);
    chk("rst_en",    bus_enable, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_ready", in_ready,   1'b1);
    chk("rst_busy",  busy,       1'b0);
    @(posedge CLK); #2;
    RST = 1'b0;
    @(posedge CLK); #2;

    // Single word: latency and enable window
    push_word(8'hA5);
    chk("t1_count_e0", fifo_count, 3'd1);
    chk("t1_bus_e0",   Unsync_bus, 8'h00);
    #(-1 + 1);
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK); #1;
      if (k == 1) begin
        chk("t1_bus_e1", Unsync_bus, 8'hA5);
        chk("t1_en_e1",  bus_enable, 1'b0);
      end
      if (k >= 2 && k <= 5) chk("t1_en_high", bus_enable, 1'b1);
      if (k == 6) chk("t1_en_e6", bus_enable, 1'b0);
      if (k == 9) chk("t1_busy_e9", busy, 1'b1);
      if (k == 10) chk("t1_busy_e10", busy, 1'b0);
      #1;
    end

    // Five words back-to-back into a depth-4 FIFO
    cap_log.delete();
    rise_log.delete();
    for (int i = 0; i < 5; i++) push_word(t2_exp[i]);
    chk("t2_full_count", fifo_count, 3'd4);
    chk("t2_full_ready", in_ready, 1'b0);
    wait_idle();
    chk("t2_words", cap_log.size(), 5);
    if (cap_log.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("t2_word", cap_log[i], t2_exp[i]);
      for (int i = 1; i < 5; i++) chk("t2_spacing", rise_log[i] - rise_log[i-1], 10);
    end

    // Valid held while full: refused on the pop edge, accepted on the next
    for (int i = 0; i < 5; i++) push_word(8'h60 + 8'(i));
    push_word(8'h65);
    chk("t3_waited", last_wait > 0, 1);
    chk("t3_cnt_at_accept", last_cnt, 3);
    chk("t3_count_after", fifo_count, 3'd4);
    wait_idle();

    // Asynchronous reset during HOLD
    push_word(8'h77);
    push_word(8'h78);
    push_word(8'h79);
    for (int n = 0; n < 50 && !bus_enable; n++) begin
      @(posedge CLK); #2;
    end
    chk("t4_in_hold", bus_enable, 1'b1);
    #1;
    RST = 1'b1;
    #1;
    chk("t4_rst_en",    bus_enable, 1'b0);
    chk("t4_rst_bus",   Unsync_bus, 8'h00);
    chk("t4_rst_count", fifo_count, 3'd0);
    @(posedge CLK); #2;
    RST = 1'b0;
    @(posedge CLK); #2;
    cap_log.delete();
    push_word(8'h3C);
    wait_idle();
    chk("t4_after_words", cap_log.size(), 1);
    if (cap_log.size() == 1) chk("t4_after_word", cap_log[0], 8'h3C);

    // Random pushes with idle gaps
    cap_log.delete();
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(posedge CLK); #2;
      end
      push_word(8'($urandom));
    end
    wait_idle();
    chk("t5_words", cap_log.size(), 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
